// File: rtl/ad_shuffle_transpose_bank.sv
// One ping-pong bank of the corner turn: NUM_GROUPS rows of WORDS_PER_GROUP words.
// A whole row (one input group) is written per beat; reads return one column,
// i.e. word rd_col of every row, through a combinational mux.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset (clears the array)
//   wr_en        write wr_data into row wr_row on this edge
//   wr_row       row index (input group number within the frame)
//   wr_data      one group; word w at [w*WORD_WIDTH +: WORD_WIDTH]
//   rd_col       column index (output beat number within the frame)
//   rd_data      word g = mem[g][rd_col]
module ad_shuffle_transpose_bank #(
    parameter int unsigned NUM_GROUPS      = 2,
    parameter int unsigned WORDS_PER_GROUP = 4,
    parameter int unsigned WORD_WIDTH      = 16,
    localparam int unsigned ROW_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int unsigned COL_W = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  wr_en,
    input  logic [ROW_W-1:0]                      wr_row,
    input  logic [WORDS_PER_GROUP*WORD_WIDTH-1:0] wr_data,
    input  logic [COL_W-1:0]                      rd_col,
    output logic [NUM_GROUPS*WORD_WIDTH-1:0]      rd_data
);

    logic [WORD_WIDTH-1:0] mem [NUM_GROUPS][WORDS_PER_GROUP];

    // Indices are compared against loop constants rather than used directly so
    // that degenerate 1-entry dimensions never see an out-of-range index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NUM_GROUPS; r++) begin
                for (int unsigned w = 0; w < WORDS_PER_GROUP; w++) begin
                    mem[r][w] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int unsigned r = 0; r < NUM_GROUPS; r++) begin
                if (wr_row == ROW_W'(r)) begin
                    for (int unsigned w = 0; w < WORDS_PER_GROUP; w++) begin
                        mem[r][w] <= wr_data[w*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            for (int unsigned c = 0; c < WORDS_PER_GROUP; c++) begin
                if (rd_col == COL_W'(c)) begin
                    rd_data[g*WORD_WIDTH +: WORD_WIDTH] = mem[g][c];
                end
            end
        end
    end

endmodule

// File: rtl/ad_shuffle_transpose.sv
// Streaming double-buffered perfect shuffle (corner turn).
// NUM_GROUPS input beats of WORDS_PER_GROUP words form a frame; the frame is
// emitted as WORDS_PER_GROUP output beats, beat j carrying word j of every group.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   s_valid/s_ready/s_data       input stream, one group per beat
//   s_last                       producer frame marker, only checked
//   m_valid/m_ready/m_data       output stream, one column per beat
//   m_last                       marks the last output beat of a frame
//   frame_err, frame_err_clr     sticky s_last misalignment flag and its clear
module ad_shuffle_transpose #(
    parameter int unsigned NUM_GROUPS      = 2,
    parameter int unsigned WORDS_PER_GROUP = 4,
    parameter int unsigned WORD_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [WORDS_PER_GROUP*WORD_WIDTH-1:0] s_data,
    input  logic                                  s_last,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [NUM_GROUPS*WORD_WIDTH-1:0]      m_data,
    output logic                                  m_last,
    output logic                                  frame_err,
    input  logic                                  frame_err_clr
);

    localparam int unsigned WR_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned RD_W = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1;

    logic            en_q;
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [WR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
    logic            frame_err_q, frame_err_d;

    logic s_fire, m_fire, wr_last, rd_last;
    logic [NUM_GROUPS*WORD_WIDTH-1:0] rd_data0, rd_data1;

    // With a single-entry dimension the *_last compare is always true, so the
    // counter stays tied at 0 and every beat completes a frame.
    assign wr_last = (wr_cnt_q == WR_W'(NUM_GROUPS - 1));
    assign rd_last = (rd_cnt_q == RD_W'(WORDS_PER_GROUP - 1));

    assign s_ready   = en_q & ~full_q[wr_bank_q];
    assign m_valid   = full_q[rd_bank_q];
    assign s_fire    = s_valid & s_ready;
    assign m_fire    = m_valid & m_ready;
    assign m_last    = m_valid & rd_last;
    assign m_data    = rd_bank_q ? rd_data1 : rd_data0;
    assign frame_err = frame_err_q;

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        frame_err_d = frame_err_q;

        if (s_fire) begin
            if (wr_last) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // The write bank is never full while being written, so the read bank
        // (full) is always the other one: both updates can apply together.
        if (m_fire) begin
            if (rd_last) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end

        // Set wins over clear.
        if (frame_err_clr) begin
            frame_err_d = 1'b0;
        end
        if (s_fire && (s_last != wr_last)) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q        <= 1'b0;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            en_q        <= 1'b1;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    ad_shuffle_transpose_bank #(
        .NUM_GROUPS      (NUM_GROUPS),
        .WORDS_PER_GROUP (WORDS_PER_GROUP),
        .WORD_WIDTH      (WORD_WIDTH)
    ) u_bank0 (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (s_fire & ~wr_bank_q),
        .wr_row  (wr_cnt_q),
        .wr_data (s_data),
        .rd_col  (rd_cnt_q),
        .rd_data (rd_data0)
    );

    ad_shuffle_transpose_bank #(
        .NUM_GROUPS      (NUM_GROUPS),
        .WORDS_PER_GROUP (WORDS_PER_GROUP),
        .WORD_WIDTH      (WORD_WIDTH)
    ) u_bank1 (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (s_fire & wr_bank_q),
        .wr_row  (wr_cnt_q),
        .wr_data (s_data),
        .rd_col  (rd_cnt_q),
        .rd_data (rd_data1)
    );

endmodule
